// File: rtl/audio_pkg.sv
// Shared constants and FSM encoding for the microphone level path.
package audio_pkg;

  // Sample value for silence (12-bit offset-binary mic stream).
  localparam int unsigned MIDPOINT  = 2048;
  // Largest representable 6-bit volume level.
  localparam int unsigned LEVEL_MAX = 63;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    CALC   = 2'd1,
    UPDATE = 2'd2
  } state_t;

endpackage

// File: rtl/mic_volume_meter_if.sv
// Sample stream in, smoothed level out.
interface mic_volume_meter_if #(
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned LEVEL_W  = 6
);
  logic                sample_valid;
  logic [SAMPLE_W-1:0] mic_in;
  logic                freeze;
  logic [LEVEL_W-1:0]  volume_level;
  logic                level_update;
  logic [SAMPLE_W-1:0] peak_raw;

  // Sample source / level consumer side.
  modport master (
    output sample_valid, mic_in, freeze,
    input  volume_level, level_update, peak_raw
  );

  // Meter side.
  modport slave (
    input  sample_valid, mic_in, freeze,
    output volume_level, level_update, peak_raw
  );
endinterface

// File: rtl/mic_peak_window.sv
// Windowed peak accumulator: tracks the maximum sample over a fixed number of
// accepted samples and publishes it when the window closes.
module mic_peak_window #(
  parameter int unsigned SAMPLE_W       = 12,
  parameter int unsigned WINDOW_SAMPLES = 4000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid_i,
  input  logic [SAMPLE_W-1:0] mic_in_i,
  output logic [SAMPLE_W-1:0] peak_raw_o,
  output logic                window_done_o
);
  localparam int unsigned CNT_W = $clog2(WINDOW_SAMPLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW_SAMPLES - 1);

  logic [SAMPLE_W-1:0] peak_acc_q, peak_acc_d;
  logic [SAMPLE_W-1:0] peak_raw_q, peak_raw_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [SAMPLE_W-1:0] sample_max;
  logic                closing;

  // Next accumulator values; idle cycles leave everything untouched.
  always_comb begin
    sample_max = (mic_in_i > peak_acc_q) ? mic_in_i : peak_acc_q;
    closing    = sample_valid_i && (count_q == LAST);
    peak_acc_d = peak_acc_q;
    peak_raw_d = peak_raw_q;
    count_d    = count_q;
    if (closing) begin
      peak_raw_d = sample_max;
      peak_acc_d = '0;
      count_d    = '0;
    end else if (sample_valid_i) begin
      peak_acc_d = sample_max;
      count_d    = count_q + CNT_W'(1);
    end
  end

  // Accumulator registers; reset discards any partial window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_acc_q <= '0;
      peak_raw_q <= '0;
      count_q    <= '0;
    end else begin
      peak_acc_q <= peak_acc_d;
      peak_raw_q <= peak_raw_d;
      count_q    <= count_d;
    end
  end

  // Window end is flagged combinationally so the FSM leaves ACCUM on the
  // same edge that registers peak_raw, keeping the level two edges later.
  assign window_done_o = closing;
  assign peak_raw_o    = peak_raw_q;

endmodule

// File: rtl/mic_volume_meter.sv
// Microphone volume meter: windowed peak -> quantised level with fast attack
// and one-step-per-window decay, published with a one-cycle update pulse.
module mic_volume_meter #(
  parameter int unsigned SAMPLE_W       = 12,
  parameter int unsigned MIDPOINT       = audio_pkg::MIDPOINT,
  parameter int unsigned WINDOW_SAMPLES = 4000,
  parameter int unsigned LEVEL_SHIFT    = 5,
  parameter int unsigned LEVEL_W        = 6
) (
  input  logic           clk12p5mhz_clk,
  input  logic           rst_n,
  mic_volume_meter_if.slave bus
);
  import audio_pkg::*;

  localparam int unsigned LEVEL_SAT = (1 << LEVEL_W) - 1;
  localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(MIDPOINT);

  state_t              state_q, state_d;
  logic [SAMPLE_W-1:0] peak_raw;
  logic                window_done;
  logic [SAMPLE_W-1:0] diff, scaled;
  logic [LEVEL_W-1:0]  raw_calc;
  logic [LEVEL_W-1:0]  raw_q, raw_d;
  logic [LEVEL_W-1:0]  volume_q, volume_d;
  logic                update_q, update_d;

  mic_peak_window #(
    .SAMPLE_W       (SAMPLE_W),
    .WINDOW_SAMPLES (WINDOW_SAMPLES)
  ) u_peak_window (
    .clk            (clk12p5mhz_clk),
    .rst_n          (rst_n),
    .sample_valid_i (bus.sample_valid),
    .mic_in_i       (bus.mic_in),
    .peak_raw_o     (peak_raw),
    .window_done_o  (window_done)
  );

  // Quantise the window peak above midpoint, saturating at the top level.
  always_comb begin
    diff   = peak_raw - MID;
    scaled = diff >> LEVEL_SHIFT;
    if (peak_raw <= MID) begin
      raw_calc = '0;
    end else if (scaled > SAMPLE_W'(LEVEL_SAT)) begin
      raw_calc = LEVEL_W'(LEVEL_SAT);
    end else begin
      raw_calc = scaled[LEVEL_W-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk12p5mhz_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (window_done) state_d = CALC;
      CALC:    state_d = UPDATE;
      UPDATE:  state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // FSM outputs: latch the quantised level in CALC, smooth and publish in UPDATE.
  always_comb begin
    raw_d    = raw_q;
    volume_d = volume_q;
    update_d = 1'b0;
    unique case (state_q)
      CALC: raw_d = raw_calc;
      UPDATE: begin
        if (!bus.freeze) begin
          update_d = 1'b1;
          if (raw_q >= volume_q) begin
            volume_d = raw_q;
          end else begin
            volume_d = volume_q - LEVEL_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Level datapath registers.
  always_ff @(posedge clk12p5mhz_clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q    <= '0;
      volume_q <= '0;
      update_q <= 1'b0;
    end else begin
      raw_q    <= raw_d;
      volume_q <= volume_d;
      update_q <= update_d;
    end
  end

  assign bus.volume_level = volume_q;
  assign bus.level_update = update_q;
  assign bus.peak_raw     = peak_raw;

endmodule

// File: tb/tb_mic_volume_meter.sv
// Scoreboard bench for mic_volume_meter with an 8-sample window.
module tb_mic_volume_meter;

  typedef struct {
    int unsigned level;
    int unsigned peak;
    int unsigned due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_pass;
  exp_t        sb_q[$];

  mic_volume_meter_if #(.SAMPLE_W(12), .LEVEL_W(6)) bus ();

  mic_volume_meter #(
    .SAMPLE_W       (12),
    .MIDPOINT       (2048),
    .WINDOW_SAMPLES (8),
    .LEVEL_SHIFT    (5),
    .LEVEL_W        (6)
  ) dut (
    .clk12p5mhz_clk (clk),
    .rst_n          (rst_n),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every update pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && bus.level_update) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("level", 32'(bus.volume_level), e.level);
        check("peak_raw", 32'(bus.peak_raw), e.peak);
        check("pulse_cycle", cyc, e.due);
      end
    end
  end

  // Eight samples of `fill`, with `pk` substituted at position `pos`,
  // `gap` idle cycles after each sample.
  task automatic send_window(input logic [11:0] fill, input logic [11:0] pk,
                             input int unsigned pos, input int unsigned gap,
                             input bit expect_pulse, input int unsigned exp_lvl,
                             input int unsigned exp_peak);
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.sample_valid = 1'b1;
      bus.mic_in       = (i == pos) ? pk : fill;
      @(negedge clk);
      bus.sample_valid = 1'b0;
      if (i == 7 && expect_pulse) begin
        exp_t e;
        e.level = exp_lvl;
        e.peak  = exp_peak;
        e.due   = cyc + 2;
        sb_q.push_back(e);
      end
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_level", 32'(bus.volume_level), 0);
    check("rst_update", 32'(bus.level_update), 0);
    check("rst_peak_raw", 32'(bus.peak_raw), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    cyc              = 0;
    n_checks         = 0;
    n_pass           = 0;
    rst_n            = 1'b0;
    bus.sample_valid = 1'b0;
    bus.mic_in       = 12'd0;
    bus.freeze       = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Partial stream, then reset mid-stream.
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.sample_valid = 1'b1;
      bus.mic_in       = 12'd4095;
      @(negedge clk);
      bus.sample_valid = 1'b0;
    end
    pulse_reset();

    // Silence; first seven samples must not pulse, eighth pulses at E+2.
    send_window(12'd2048, 12'd2048, 0, 0, 1'b1, 0, 2048);
    drain();

    // Quantise: (2368-2048)>>5 = 10, with gaps in sample_valid.
    send_window(12'd2048, 12'd2368, 3, 2, 1'b1, 10, 2368);
    drain();

    // Saturation then one-step decay.
    send_window(12'd2048, 12'd4095, 5, 1, 1'b1, 63, 4095);
    drain();
    send_window(12'd2048, 12'd2048, 0, 0, 1'b1, 62, 2048);
    drain();
    send_window(12'd2048, 12'd2048, 0, 1, 1'b1, 61, 2048);
    drain();
    send_window(12'd2048, 12'd2048, 0, 0, 1'b1, 60, 2048);
    drain();

    // Reset mid-window: five loud samples discarded.
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.sample_valid = 1'b1;
      bus.mic_in       = 12'd4095;
      @(negedge clk);
      bus.sample_valid = 1'b0;
    end
    pulse_reset();
    send_window(12'd2048, 12'd2048, 0, 0, 1'b1, 0, 2048);
    drain();

    // Level 20: (2688-2048)>>5 = 20.
    send_window(12'd2048, 12'd2688, 7, 0, 1'b1, 20, 2688);
    drain();

    // Frozen window with peak 4095: no pulse, level held, peak_raw still moves.
    bus.freeze = 1'b1;
    send_window(12'd2048, 12'd4095, 7, 0, 1'b0, 0, 0);
    repeat (6) @(negedge clk);
    check("frozen_level", 32'(bus.volume_level), 20);
    check("frozen_peak_raw", 32'(bus.peak_raw), 4095);
    bus.freeze = 1'b0;

    // Silent window after unfreeze decays by one.
    send_window(12'd2048, 12'd2048, 0, 0, 1'b1, 19, 2048);
    drain();

    repeat (5) @(negedge clk);
    check("final_level", 32'(bus.volume_level), 19);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
